ise_sched: RTL and testbench

ISE_SCHED -- requirements
Module: ise_sched

---
 rtl/ise_sched.sv | 187 ++++++++++++++++++
 tb/tb_ise_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ise_sched.sv
// ise_sched: streams NUM_IMG images of PIX_PER_IMG pixels from ROM to the classifier and
// collects one {image, color} result per image. Define ISE_SCHED_TIMEOUT_EN for the busy watchdog.
module ise_sched #(
   parameter int unsigned NUM_IMG      = 32,
   parameter int unsigned PIX_PER_IMG  = 16384,
   parameter int unsigned BUSY_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        rom_rd,
   output logic [18:0] rom_addr,
   input  logic [23:0] rom_data,
   input  logic        ise_busy,
   output logic        ise_pixel_valid,
   output logic [23:0] ise_pixel,
   output logic [4:0]  ise_image_index,
   input  logic        ise_out_valid,
   input  logic [1:0]  ise_color,
   input  logic [4:0]  ise_image_out,
   input  logic [4:0]  res_rd_addr,
   output logic [6:0]  res_rd_data,
   output logic        done,
   output logic        error
);

   localparam int unsigned IMG_W     = 5;
   localparam int unsigned PIX_W     = 14;
   localparam int unsigned RES_W     = 6;
   localparam int unsigned BUF_DEPTH = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_HI,
      S_WAIT_LO,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IMG_W-1:0] r_img_cnt;
   logic [IMG_W-1:0] w_img_cnt_nxt;
   logic [PIX_W-1:0] r_pix_cnt;
   logic [PIX_W-1:0] w_pix_cnt_nxt;
   logic [RES_W-1:0] r_res_cnt;
   logic [RES_W-1:0] w_res_cnt_nxt;
   logic [IMG_W-1:0] r_img_idx;
   logic [IMG_W-1:0] w_img_idx_nxt;
   logic             r_pix_vld;
   logic             r_done;
   logic             w_rd;
   logic             w_res_wr;
   logic             w_start_ok;
   logic             w_timeout;
   logic [6:0]       r_buf [BUF_DEPTH];

`ifdef ISE_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_error;
   logic            w_in_wait;

   assign w_in_wait = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
   assign w_timeout = w_in_wait && (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1));
   assign error     = r_error;

   // Watchdog restarts on every state change; error is sticky until the next accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt <= '0;
         r_error  <= 1'b0;
      end else begin
         if (!w_in_wait || (w_state_nxt != r_state)) r_to_cnt <= '0;
         else                                        r_to_cnt <= r_to_cnt + TO_W'(1);
         if (w_start_ok)     r_error <= 1'b0;
         else if (w_timeout) r_error <= 1'b1;
      end
   end
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (BUSY_TIMEOUT == 0);
   assign w_timeout        = 1'b0;
   assign error            = 1'b0;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_img_cnt_nxt = r_img_cnt;
      w_pix_cnt_nxt = r_pix_cnt;
      w_img_idx_nxt = r_img_idx;
      w_res_cnt_nxt = r_res_cnt;
      w_rd          = 1'b0;
      w_start_ok    = 1'b0;
      // Results are accepted in every active state until the buffer is full.
      w_res_wr      = ise_out_valid && (r_state != S_IDLE) && (r_state != S_DONE) &&
                      (r_res_cnt < RES_W'(NUM_IMG));

      case (r_state)
         S_IDLE: begin
            if (start) w_start_ok = 1'b1;
         end
         S_FETCH: begin
            if (!ise_busy) begin
               w_rd = 1'b1;
               if (r_pix_cnt == PIX_W'(PIX_PER_IMG - 1)) begin
                  w_pix_cnt_nxt = '0;
                  w_state_nxt   = S_WAIT_HI;
               end else begin
                  w_pix_cnt_nxt = r_pix_cnt + PIX_W'(1);
               end
            end
         end
         S_WAIT_HI: begin
            if (w_timeout)     w_state_nxt = S_DONE;
            else if (ise_busy) w_state_nxt = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (w_timeout) begin
               w_state_nxt = S_DONE;
            end else if (!ise_busy) begin
               if (r_img_cnt == IMG_W'(NUM_IMG - 1)) begin
                  w_state_nxt = S_COLLECT;
               end else begin
                  w_img_cnt_nxt = r_img_cnt + IMG_W'(1);
                  w_img_idx_nxt = r_img_cnt + IMG_W'(1);
                  w_state_nxt   = S_FETCH;
               end
            end
         end
         S_COLLECT: begin
            if (r_res_cnt == RES_W'(NUM_IMG)) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (start) w_start_ok = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_res_wr) w_res_cnt_nxt = r_res_cnt + RES_W'(1);

      if (w_start_ok) begin
         w_state_nxt   = S_FETCH;
         w_img_cnt_nxt = '0;
         w_pix_cnt_nxt = '0;
         w_img_idx_nxt = '0;
         w_res_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_img_cnt <= '0;
         r_pix_cnt <= '0;
         r_res_cnt <= '0;
         r_img_idx <= '0;
         r_pix_vld <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_img_cnt <= w_img_cnt_nxt;
         r_pix_cnt <= w_pix_cnt_nxt;
         r_res_cnt <= w_res_cnt_nxt;
         r_img_idx <= w_img_idx_nxt;
         r_pix_vld <= w_rd;
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   // Result buffer has no reset; contents are only meaningful after results arrive.
   always_ff @(posedge clk) begin
      if (w_res_wr) r_buf[r_res_cnt[IMG_W-1:0]] <= {ise_image_out, ise_color};
   end

   assign rom_rd          = w_rd;
   assign rom_addr        = {r_img_cnt, r_pix_cnt};
   assign ise_pixel_valid = r_pix_vld;
   assign ise_pixel       = rom_data;
   assign ise_image_index = r_img_idx;
   assign res_rd_data     = r_buf[res_rd_addr];
   assign done            = r_done;

endmodule

// File: tb/tb_ise_sched.sv
// tb_ise_sched: directed bench for ise_sched with address, pixel and result scoreboards.
module tb_ise_sched;

   localparam int unsigned NUM_IMG = 32;
   localparam int unsigned PIX     = 64;
   localparam int unsigned TMO     = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        rom_rd;
   logic [18:0] rom_addr;
   logic [23:0] rom_data;
   logic        ise_busy;
   logic        busy_force;
   logic        busy_model;
   logic        model_en;
   logic        ise_pixel_valid;
   logic [23:0] ise_pixel;
   logic [4:0]  ise_image_index;
   logic        ise_out_valid;
   logic [1:0]  ise_color;
   logic [4:0]  ise_image_out;
   logic [4:0]  res_rd_addr;
   logic [6:0]  res_rd_data;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_count = 0;
   int bcnt     = 0;
   int rd_snap  = 0;

   logic [18:0] exp_addr [$];
   logic [23:0] exp_pix  [$];
   logic [6:0]  exp_res  [$];

   ise_sched #(
      .NUM_IMG      (NUM_IMG),
      .PIX_PER_IMG  (PIX),
      .BUSY_TIMEOUT (TMO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .rom_rd          (rom_rd),
      .rom_addr        (rom_addr),
      .rom_data        (rom_data),
      .ise_busy        (ise_busy),
      .ise_pixel_valid (ise_pixel_valid),
      .ise_pixel       (ise_pixel),
      .ise_image_index (ise_image_index),
      .ise_out_valid   (ise_out_valid),
      .ise_color       (ise_color),
      .ise_image_out   (ise_image_out),
      .res_rd_addr     (res_rd_addr),
      .res_rd_data     (res_rd_data),
      .done            (done),
      .error           (error)
   );

   always #5 clk = ~clk;

   assign ise_busy = busy_force | busy_model;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // ROM model: data tagged with the address it was read from, one cycle after rom_rd.
   always @(posedge clk) begin
      rom_data <= rom_rd ? {5'h15, rom_addr} : 24'h0;
   end

   // Classifier busy model: busy for 10 cycles starting the cycle after an image's last pixel.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_model <= 1'b0;
         bcnt       <= 0;
      end else if (model_en && rom_rd && (rom_addr[13:0] == 14'(PIX - 1))) begin
         busy_model <= 1'b1;
         bcnt       <= 10;
      end else if (bcnt > 0) begin
         bcnt       <= bcnt - 1;
         busy_model <= (bcnt > 1);
      end
   end

   // Output monitor: every read address and every streamed pixel against the scoreboards.
   always @(negedge clk) begin
      if (!reset) begin
         if (ise_pixel_valid) begin
            check("pix_pending", (exp_pix.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_pix.size() > 0) check("ise_pixel", ise_pixel, exp_pix.pop_front());
         end
         if (rom_rd) begin
            rd_count++;
            exp_pix.push_back({5'h15, rom_addr});
            check("rd_expected", (exp_addr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_addr.size() > 0) begin
               check("rom_addr", rom_addr, exp_addr.pop_front());
               check("img_index", ise_image_index, rom_addr[18:14]);
            end
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_addr(input logic [18:0] a, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (rom_rd && (rom_addr == a)) found = 1'b1;
      end
      #1;
      check("wait_addr", 32'(found), 32'd1);
   endtask

   task automatic wait_stream(input int budget);
      for (int i = 0; i < budget && exp_addr.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      check("stream_done", exp_addr.size(), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      busy_force    = 1'b0;
      model_en      = 1'b0;
      ise_out_valid = 1'b0;
      ise_color     = 2'd0;
      ise_image_out = 5'd0;
      res_rd_addr   = 5'd0;

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_rom_rd", rom_rd, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_pix_valid", ise_pixel_valid, 0);
      check("rst_img_index", ise_image_index, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      @(posedge clk); #1 reset = 1'b0;

      // Full run with a mid-image stall and an ignored start during FETCH.
      model_en = 1'b1;
      for (int i = 0; i < int'(NUM_IMG); i++)
         for (int p = 0; p < int'(PIX); p++)
            exp_addr.push_back({5'(i), 14'(p)});
      pulse_start();

      wait_addr(19'd19, 200);
      @(posedge clk); #1 busy_force = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("stall_rd", rom_rd, 0);
      end
      @(posedge clk); #1 busy_force = 1'b0;
      @(negedge clk);
      check("resume_rd", rom_rd, 1);
      check("resume_addr", rom_addr, 19'd20);

      wait_addr(19'h04000, 200);
      check("img1_index", ise_image_index, 1);
      check("img1_rd_count", rd_count, PIX + 1);

      wait_addr({5'd2, 14'd10}, 400);
      pulse_start();

      wait_stream(4000);
      repeat (15) @(negedge clk);
      #1;
      check("rd_total", rd_count, NUM_IMG * PIX);
      check("collect_done", done, 0);
      check("collect_rd", rom_rd, 0);
      check("last_index", ise_image_index, NUM_IMG - 1);

      for (int k = 0; k < int'(NUM_IMG); k++) begin
         @(posedge clk); #1;
         ise_out_valid = 1'b1;
         ise_image_out = 5'(31 - k);
         ise_color     = 2'(k % 3);
         exp_res.push_back({5'(31 - k), 2'(k % 3)});
      end
      @(posedge clk); #1 ise_out_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("run_done", done, 1);
      check("run_error", error, 0);

      @(posedge clk); #1;
      ise_out_valid = 1'b1;
      ise_image_out = 5'h1F;
      ise_color     = 2'd3;
      @(posedge clk); #1 ise_out_valid = 1'b0;
      @(negedge clk); #1;
      check("done_hold", done, 1);

      for (int k = 0; k < int'(NUM_IMG); k++) begin
         res_rd_addr = 5'(k);
         #1;
         check("res_buf", res_rd_data, exp_res.pop_front());
      end

      // Restart from DONE, then reset in the middle of image 3.
      for (int i = 0; i < 3; i++)
         for (int p = 0; p < int'(PIX); p++)
            exp_addr.push_back({5'(i), 14'(p)});
      for (int p = 0; p <= 30; p++)
         exp_addr.push_back({5'd3, 14'(p)});
      pulse_start();
      check("restart_done", done, 0);
      wait_addr({5'd3, 14'd30}, 1000);
      reset = 1'b1;
      @(negedge clk); #1;
      check("midrst_rd", rom_rd, 0);
      check("midrst_pix_valid", ise_pixel_valid, 0);
      check("midrst_done", done, 0);
      check("midrst_index", ise_image_index, 0);
      check("midrst_addr", rom_addr, 0);
      check("midrst_queue", exp_addr.size(), 0);
      exp_pix.delete();
      @(posedge clk); #1 reset = 1'b0;
      rd_snap = rd_count;
      repeat (20) @(negedge clk);
      #1;
      check("post_rst_no_rd", rd_count, rd_snap);
      check("post_rst_done", done, 0);

      // Classifier never raises busy after image 0.
      model_en = 1'b0;
      for (int p = 0; p < int'(PIX); p++)
         exp_addr.push_back({5'd0, 14'(p)});
      pulse_start();
      wait_stream(300);
      repeat (TMO + 20) @(negedge clk);
      #1;
`ifdef ISE_SCHED_TIMEOUT_EN
      check("tmo_error", error, 1);
      check("tmo_done", done, 1);
`else
      check("tmo_error", error, 0);
      check("tmo_done", done, 0);
      check("tmo_rd", rom_rd, 0);
      check("tmo_index", ise_image_index, 0);
`endif
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); #1;
      check("final_error", error, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
